dual_input_debouncer: RTL and testbench

- Upstream conditioning stage for the two-input Moore/Mealy controller.
- Takes two raw, asynchronous, bouncy inputs (push-buttons or switches).
- Synchronises and debounces each one, then drives clean level signals `a` and `b` plus one-cycle rising-edge pulses.
- Downstream FSM may therefore sample `a`/`b` directly with no metastability or chatter concerns.

---
 rtl/dual_input_debouncer.sv | 97 +++++++++
 tb/tb_dual_input_debouncer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/dual_input_debouncer.sv
// dual_input_debouncer: two-channel synchroniser + debouncer with rising-edge pulses; DEB_ALIGN_EN adds rising-edge coincidence alignment
module dual_input_debouncer #(
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W = 8
`ifdef DEB_ALIGN_EN
    ,
    parameter int ALIGN_WIN = 2
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic a_raw,
    input  logic b_raw,
    output logic a,
    output logic b,
    output logic a_pulse,
    output logic b_pulse
);
    typedef enum logic [1:0] {LOW = 2'b00, RISE_WAIT = 2'b01, HIGH = 2'b10, FALL_WAIT = 2'b11} state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    logic [1:0] s1, s2, lv, pl, q, fall, rise;
    state_t st [2];
    logic [CNT_W-1:0] cnt [2];
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            q[i] = st[i] == RISE_WAIT && s2[i] && cnt[i] == LAST;
            fall[i] = st[i] == FALL_WAIT && !s2[i] && cnt[i] == LAST;
        end
    end
`ifdef DEB_ALIGN_EN
    // a qualified rise is held while the other level is low, until the partner qualifies or the window expires
    logic [1:0] pend, live, start;
    logic [7:0] w;
    always_comb begin
        for (int i = 0; i < 2; i++)
            live[i] = pend[i] && !(st[i] == HIGH && !s2[i]);
        for (int i = 0; i < 2; i++) begin
            rise[i] = (q[i] && (lv[1-i] || q[1-i] || live[1-i]))
                   || (live[i] && (q[1-i] || w == 8'(ALIGN_WIN - 1)));
            start[i] = q[i] && !lv[1-i] && !q[1-i] && !live[1-i];
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            pend <= '0;
            w <= '0;
        end else begin
            pend <= start | (live & ~rise);
            w <= |start ? 8'd0 : w + 8'd1;
        end
    end
`else
    assign rise = q;
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
            lv <= '0;
            pl <= '0;
            for (int i = 0; i < 2; i++) begin
                st[i] <= LOW;
                cnt[i] <= '0;
            end
        end else begin
            s1 <= {b_raw, a_raw};
            s2 <= s1;
            pl <= rise;
            lv <= (lv | rise) & ~fall;
            for (int i = 0; i < 2; i++) begin
                case (st[i])
                    LOW: begin
                        st[i] <= s2[i] ? RISE_WAIT : LOW;
                        cnt[i] <= s2[i] ? ONE : '0;
                    end
                    RISE_WAIT: begin
                        st[i] <= !s2[i] ? LOW : cnt[i] == LAST ? HIGH : RISE_WAIT;
                        cnt[i] <= (!s2[i] || cnt[i] == LAST) ? '0 : cnt[i] + ONE;
                    end
                    HIGH: begin
                        st[i] <= s2[i] ? HIGH : FALL_WAIT;
                        cnt[i] <= s2[i] ? '0 : ONE;
                    end
                    default: begin
                        st[i] <= s2[i] ? HIGH : cnt[i] == LAST ? LOW : FALL_WAIT;
                        cnt[i] <= (s2[i] || cnt[i] == LAST) ? '0 : cnt[i] + ONE;
                    end
                endcase
            end
        end
    end
    assign a = lv[0];
    assign b = lv[1];
    assign a_pulse = pl[0];
    assign b_pulse = pl[1];
endmodule

// File: tb/tb_dual_input_debouncer.sv
// tb_dual_input_debouncer: directed stimulus with a run-length reference model and literal checkpoints
module tb_dual_input_debouncer;
    localparam int DEB = 4;
    logic clk = 0, reset = 1, a_raw = 0, b_raw = 0;
    logic a, b, a_pulse, b_pulse;
    int errors = 0, checks = 0;
    bit model_on = 0;
    logic [1:0] m_s1, m_s2, m_lv, m_pl;
    int m_run [2];

    dual_input_debouncer #(.DEB_CYCLES(DEB), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .a_raw(a_raw), .b_raw(b_raw),
        .a(a), .b(b), .a_pulse(a_pulse), .b_pulse(b_pulse)
    );

    always #5 clk = ~clk;

    // level flips once the synchronised input has disagreed with it for DEB consecutive samples
    always @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            int r;
            logic l, p;
            if (reset) begin
                m_s1[c] <= 0; m_s2[c] <= 0; m_lv[c] <= 0; m_pl[c] <= 0; m_run[c] <= 0;
            end else begin
                r = (m_s2[c] != m_lv[c]) ? m_run[c] + 1 : 0;
                l = m_lv[c];
                p = 0;
                if (r >= DEB) begin
                    l = m_s2[c];
                    p = m_s2[c];
                    r = 0;
                end
                m_run[c] <= r; m_lv[c] <= l; m_pl[c] <= p;
                m_s2[c] <= m_s1[c];
                m_s1[c] <= (c == 0) ? a_raw : b_raw;
            end
        end
    end

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (model_on) begin
            check("model_a", a, m_lv[0]);
            check("model_b", b, m_lv[1]);
            check("model_a_pulse", a_pulse, m_pl[0]);
            check("model_b_pulse", b_pulse, m_pl[1]);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
`ifndef DEB_ALIGN_EN
        logic [47:0] pa, pb;
        model_on = 1;
        reset = 1; a_raw = 1; b_raw = 1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("rst_a", a, 0); check("rst_b", b, 0);
            check("rst_ap", a_pulse, 0); check("rst_bp", b_pulse, 0);
        end
        reset = 0;
        tick(5); check("t1_a_e5", a, 0);
        tick(1); check("t1_a_e6", a, 1); check("t1_ap_e6", a_pulse, 1);
        check("t1_b_e6", b, 1); check("t1_bp_e6", b_pulse, 1);
        tick(1); check("t1_ap_e7", a_pulse, 0); check("t1_a_e7", a, 1);
        a_raw = 0;
        tick(5); check("t4_a_e5", a, 1);
        tick(1); check("t4_a_e6", a, 0); check("t4_ap_e6", a_pulse, 0);
        for (int i = 0; i < 4; i++) begin
            a_raw = (i % 2 == 0);
            tick(1); check("t2_a", a, 0); check("t2_ap", a_pulse, 0);
        end
        a_raw = 0;
        for (int i = 0; i < 8; i++) begin
            tick(1); check("t2_a_tail", a, 0); check("t2_ap_tail", a_pulse, 0);
        end
        a_raw = 1;
        tick(6); check("t3_a_up", a, 1);
        tick(1);
        a_raw = 0;
        tick(2);
        a_raw = 1;
        for (int i = 0; i < 8; i++) begin
            tick(1); check("t3_a_hold", a, 1); check("t3_ap_hold", a_pulse, 0);
        end
        a_raw = 0; b_raw = 0;
        tick(8); check("t5_a_low", a, 0); check("t5_b_low", b, 0);
        a_raw = 1; b_raw = 1;
        tick(5); check("t5_a_e5", a, 0); check("t5_b_e5", b, 0);
        tick(1); check("t5_a_e6", a, 1); check("t5_b_e6", b, 1);
        check("t5_ap_e6", a_pulse, 1); check("t5_bp_e6", b_pulse, 1);
        a_raw = 0; b_raw = 0;
        tick(8);
        a_raw = 1;
        tick(3);
        reset = 1;
        tick(1); check("mid_rst_a", a, 0); check("mid_rst_ap", a_pulse, 0);
        reset = 0;
        tick(5); check("mid_rst_a_e5", a, 0);
        tick(1); check("mid_rst_a_e6", a, 1); check("mid_rst_ap_e6", a_pulse, 1);
        pa = 48'h0FF0_3C0F_FFE1;
        pb = 48'h00FF_F0E0_7FF8;
        for (int i = 47; i >= 0; i--) begin
            a_raw = pa[i]; b_raw = pb[i];
            tick(1);
        end
        a_raw = 0; b_raw = 0;
        tick(8);
`else
        reset = 1; a_raw = 0; b_raw = 0;
        tick(2);
        reset = 0;
        tick(2);
        a_raw = 1;
        tick(1);
        b_raw = 1;
        tick(5); check("al1_a_e6", a, 0);
        tick(1); check("al1_a_e7", a, 1); check("al1_b_e7", b, 1);
        check("al1_ap_e7", a_pulse, 1); check("al1_bp_e7", b_pulse, 1);
        a_raw = 0; b_raw = 0;
        tick(6); check("al_fall_a", a, 0); check("al_fall_b", b, 0);
        tick(2);
        a_raw = 1;
        tick(3);
        b_raw = 1;
        tick(3); check("al3_a_e6", a, 0);
        tick(1); check("al3_a_e7", a, 0);
        tick(1); check("al3_a_e8", a, 1); check("al3_ap_e8", a_pulse, 1); check("al3_b_e8", b, 0);
        tick(1); check("al3_b_e9", b, 1); check("al3_bp_e9", b_pulse, 1); check("al3_ap_e9", a_pulse, 0);
        a_raw = 0; b_raw = 0;
        tick(8);
        a_raw = 1;
        tick(6); check("alr_a_pend", a, 0);
        reset = 1;
        tick(1); check("alr_a_rst", a, 0); check("alr_ap_rst", a_pulse, 0);
        reset = 0; a_raw = 0;
        for (int i = 0; i < 4; i++) begin
            tick(1); check("alr_a_after", a, 0); check("alr_ap_after", a_pulse, 0);
        end
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
